// File: rtl/addsub_rr_sched_pkg.sv
// Shared types and constants for the round-robin add/subtract scheduler.
package addsub_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DONE
    } state_e;

    localparam logic OP_ADD = 1'b1;
    localparam logic OP_SUB = 1'b0;

    localparam int unsigned OPW = 16;

endpackage

// File: rtl/addsub_rr_sched_if.sv
// Request and result channels of the scheduler. The scheduler uses the slave
// view; the requesters and the result consumer use the master view.
interface addsub_rr_sched_if #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 32,
    parameter int unsigned IDW   = 2
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [16*NREQ-1:0] req_a;
    logic [16*NREQ-1:0] req_b;
    logic [NREQ-1:0]    req_op;
    logic               res_valid;
    logic               res_ready;
    logic [WIDTH-1:0]   res_data;
    logic [IDW-1:0]     res_id;
    logic               busy;

    modport slave (
        input  req_valid, req_a, req_b, req_op, res_ready,
        output req_ready, res_valid, res_data, res_id, busy
    );

    modport master (
        output req_valid, req_a, req_b, req_op, res_ready,
        input  req_ready, res_valid, res_data, res_id, busy
    );
endinterface

// File: rtl/addsub_rr_sched_arb.sv
// Combinational round-robin arbiter. The search starts at rr_ptr and wraps
// around; a grant is raised only when enable is high.
module rr_arbiter_n #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  rr_ptr,
    input  logic            enable,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx
);
    logic [IDW:0]   sum;
    logic [IDW-1:0] idx;
    logic           found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        sum       = '0;
        idx       = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            // rr_ptr + k stays below 2*NREQ, so one subtraction performs the wrap
            sum = {1'b0, rr_ptr} + (IDW+1)'(k);
            if (sum >= (IDW+1)'(NREQ)) begin
                sum = sum - (IDW+1)'(NREQ);
            end
            idx = sum[IDW-1:0];
            if (!found && req[idx]) begin
                found     = 1'b1;
                grant_idx = idx;
            end
        end
        if (enable && found) begin
            grant[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/addsub_rr_sched.sv
// Round-robin scheduler sharing one registered 16-bit add/subtract unit
// among NREQ requesters, with a backpressured result channel.
module addsub_rr_sched
    import addsub_sched_pkg::*;
#(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 32,
    parameter int unsigned IDW   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    addsub_rr_sched_if.slave      bus
);
    state_e           state_q, state_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [OPW-1:0]   a_q, a_d;
    logic [OPW-1:0]   b_q, b_d;
    logic             op_q, op_d;
    logic [WIDTH-1:0] res_data_q, res_data_d;
    logic [IDW-1:0]   res_id_q, res_id_d;
    logic             res_valid_q, res_valid_d;
    logic             busy_q, busy_d;

    logic             accept_en;
    logic             xfer;
    logic [NREQ-1:0]  grant;
    logic [IDW-1:0]   grant_idx;
    logic [WIDTH-1:0] a_ext, b_ext;

    // Accepting in DONE while res_ready is high hands the unit straight to the next winner
    assign accept_en = rst && ((state_q == IDLE) || ((state_q == DONE) && bus.res_ready));

    rr_arbiter_n #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req       (bus.req_valid),
        .rr_ptr    (rr_ptr_q),
        .enable    (accept_en),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign bus.req_ready = grant;
    assign xfer          = |grant;
    assign a_ext         = WIDTH'(a_q);
    assign b_ext         = WIDTH'(b_q);

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        id_d        = id_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        res_data_d  = res_data_q;
        res_id_d    = res_id_q;
        res_valid_d = res_valid_q;

        if (xfer) begin
            a_d      = OPW'(bus.req_a >> (OPW * grant_idx));
            b_d      = OPW'(bus.req_b >> (OPW * grant_idx));
            op_d     = bus.req_op[grant_idx];
            id_d     = grant_idx;
            rr_ptr_d = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (xfer) state_d = EXEC;
            end
            EXEC: begin
                res_data_d  = (op_q == OP_ADD) ? (a_ext + b_ext) : (a_ext - b_ext);
                res_id_d    = id_q;
                res_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                if (bus.res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = xfer ? EXEC : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            id_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= 1'b0;
            res_data_q  <= '0;
            res_id_q    <= '0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            id_q        <= id_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            res_data_q  <= res_data_d;
            res_id_q    <= res_id_d;
            res_valid_q <= res_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_id    = res_id_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_addsub_rr_sched.sv
// Self-checking bench for addsub_rr_sched: directed scenarios with literal
// expectations plus randomized traffic against a transaction-level model.
module tb_addsub_rr_sched;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    addsub_rr_sched_if #(.NREQ(4), .WIDTH(32), .IDW(2)) bus ();

    addsub_rr_sched #(.NREQ(4), .WIDTH(32), .IDW(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [31:0] ref_calc(logic [15:0] a, logic [15:0] b, logic op);
        logic [31:0] x;
        logic [31:0] y;
        x = {16'h0, a};
        y = {16'h0, b};
        return op ? (x + y) : (x - y);
    endfunction

    // Model: the unit is free, computing, or holding a result for the consumer
    int          m_stage = 0;
    int          m_ptr   = 0;
    logic        m_valid = 1'b0;
    logic [31:0] m_data  = '0;
    int          m_id    = 0;
    logic [15:0] p_a, p_b;
    logic        p_op;
    int          p_id;
    int          grant_log[$];
    logic [3:0]  xfer_seen = '0;

    always @(negedge clk) begin : compare_proc
        int         win;
        logic       can;
        logic [3:0] exp_rdy;
        logic [1:0] ix;
        if (!rst) begin
            chk("rst_req_ready", 32'(bus.req_ready), 32'h0);
            chk("rst_res_valid", 32'(bus.res_valid), 32'h0);
            chk("rst_busy",      32'(bus.busy),      32'h0);
            chk("rst_res_data",  bus.res_data,       32'h0);
            chk("rst_res_id",    32'(bus.res_id),    32'h0);
            m_stage   = 0;
            m_ptr     = 0;
            m_valid   = 1'b0;
            m_data    = '0;
            m_id      = 0;
            xfer_seen = '0;
        end else begin
            can = (m_stage == 0) || (m_stage == 2 && bus.res_ready);
            win = -1;
            if (can) begin
                for (int k = 0; k < 4; k++) begin
                    ix = 2'((m_ptr + k) % 4);
                    if (win < 0 && bus.req_valid[ix]) win = int'(ix);
                end
            end
            exp_rdy = (win >= 0) ? 4'(1 << win) : 4'b0;
            chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
            chk("res_valid", 32'(bus.res_valid), 32'(m_valid));
            chk("res_data",  bus.res_data,       m_data);
            chk("res_id",    32'(bus.res_id),    32'(m_id));
            chk("busy",      32'(bus.busy),      32'(m_stage != 0));
            xfer_seen = bus.req_valid & bus.req_ready;

            if (m_stage == 1) begin
                m_data  = ref_calc(p_a, p_b, p_op);
                m_id    = p_id;
                m_valid = 1'b1;
                m_stage = 2;
            end else if (m_stage == 2 && bus.res_ready) begin
                m_valid = 1'b0;
                m_stage = 0;
            end
            if (win >= 0) begin
                p_a     = 16'(bus.req_a >> (16 * win));
                p_b     = 16'(bus.req_b >> (16 * win));
                p_op    = bus.req_op[win[1:0]];
                p_id    = win;
                m_ptr   = (win + 1) % 4;
                m_stage = 1;
                grant_log.push_back(win);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(int i, logic [15:0] a, logic [15:0] b, logic op);
        bus.req_a[16*i +: 16] = a;
        bus.req_b[16*i +: 16] = b;
        bus.req_op[i]         = op;
        bus.req_valid[i]      = 1'b1;
    endtask

    task automatic wait_res(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.res_valid && n < 20);
    endtask

    task automatic single(string tag, int i, logic [15:0] a, logic [15:0] b, logic op,
                          logic [31:0] exp);
        int n;
        set_req(i, a, b, op);
        @(negedge clk);
        chk({tag, "_grant"}, 32'(bus.req_ready), 32'(1 << i));
        tick();
        bus.req_valid[i] = 1'b0;
        wait_res(n);
        chk({tag, "_latency"}, 32'(n), 32'd2);
        chk({tag, "_data"}, bus.res_data, exp);
        chk({tag, "_id"}, 32'(bus.res_id), 32'(i));
        tick();
    endtask

    function automatic logic [15:0] rnd_opnd();
        case ($urandom_range(0, 7))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            default: return 16'($urandom);
        endcase
    endfunction

    int exp_order[6] = '{0, 1, 2, 3, 0, 1};

    initial begin : stim
        int n;
        int vcount;
        logic [31:0] held_data;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_op    = '0;
        bus.res_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        bus.res_ready = 1'b1;

        single("add_carry", 0, 16'hFFFF, 16'h0001, 1'b1, 32'h0001_0000);
        single("add_max",   1, 16'hFFFF, 16'hFFFF, 1'b1, 32'h0001_FFFE);
        single("sub_wrap",  2, 16'd3,    16'd5,    1'b0, 32'hFFFF_FFFE);
        single("ptr_wrap",  1, 16'd10,   16'd4,    1'b0, 32'd6);

        // Backpressure: rr_ptr is 2, so req0 wins via wrap and req1 must wait
        bus.res_ready = 1'b0;
        single_hold: begin
            set_req(0, 16'd100, 16'd1, 1'b0);
            @(negedge clk);
            chk("bp_grant0", 32'(bus.req_ready), 32'h1);
            tick();
            bus.req_valid[0] = 1'b0;
            wait_res(n);
            chk("bp_latency", 32'(n), 32'd2);
            held_data = bus.res_data;
            chk("bp_data0", held_data, 32'd99);
            tick();
            set_req(1, 16'd7, 16'd8, 1'b1);
            repeat (4) begin
                @(negedge clk);
                chk("bp_hold_data",  bus.res_data,       32'd99);
                chk("bp_hold_id",    32'(bus.res_id),    32'd0);
                chk("bp_hold_valid", 32'(bus.res_valid), 32'd1);
                chk("bp_hold_ready", 32'(bus.req_ready), 32'h0);
                tick();
            end
            bus.res_ready = 1'b1;
            @(negedge clk);
            chk("bp_handoff", 32'(bus.req_ready), 32'h2);
            tick();
            bus.req_valid[1] = 1'b0;
            wait_res(n);
            chk("bp_latency1", 32'(n), 32'd2);
            chk("bp_data1", bus.res_data, 32'd15);
            chk("bp_id1", 32'(bus.res_id), 32'd1);
            tick();
        end

        // Reset while a result is held: it must vanish without a clock edge
        bus.res_ready = 1'b0;
        set_req(3, 16'd1, 16'd1, 1'b1);
        tick();
        bus.req_valid[3] = 1'b0;
        wait_res(n);
        chk("rdone_pending", 32'(bus.res_valid), 32'd1);
        tick();
        rst = 1'b0;
        #1;
        chk("rdone_valid_drop", 32'(bus.res_valid), 32'd0);
        chk("rdone_busy_drop",  32'(bus.busy),      32'd0);
        tick();
        rst = 1'b1;
        bus.res_ready = 1'b1;

        // Reset in EXEC
        set_req(2, 16'd50, 16'd20, 1'b0);
        @(negedge clk);
        chk("rexec_grant", 32'(bus.req_ready), 32'h4);
        tick();
        bus.req_valid[2] = 1'b0;
        rst = 1'b0;
        #1;
        chk("rexec_valid", 32'(bus.res_valid), 32'd0);
        chk("rexec_busy",  32'(bus.busy),      32'd0);
        tick();
        rst = 1'b1;
        repeat (5) tick();
        single("after_rst", 3, 16'd9, 16'd2, 1'b0, 32'd7);

        // Idle after reset, then fairness with all four requesting
        rst = 1'b0;
        tick();
        rst = 1'b1;
        repeat (5) tick();
        chk("idle_busy", 32'(bus.busy), 32'd0);
        grant_log.delete();
        for (int i = 0; i < 4; i++) set_req(i, 16'(i * 1000 + 5), 16'(i + 1), 1'(i % 2));
        vcount = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (c == 0) chk("fair_first", 32'(bus.req_ready), 32'h1);
            if (bus.res_valid) vcount++;
        end
        tick();
        bus.req_valid = '0;
        chk("fair_results", 32'(vcount), 32'd5);
        chk("fair_count", 32'(grant_log.size()), 32'd6);
        for (int k = 0; k < 6; k++) begin
            if (k < grant_log.size()) chk("fair_order", 32'(grant_log[k]), 32'(exp_order[k]));
        end
        repeat (3) tick();

        // Randomized traffic with legal withdrawals and random backpressure
        for (int cyc = 0; cyc < 600; cyc++) begin
            tick();
            if (cyc == 300) rst = 1'b0;
            if (cyc == 302) rst = 1'b1;
            bus.res_ready = ($urandom_range(0, 9) < 7);
            for (int i = 0; i < 4; i++) begin
                if (xfer_seen[i]) bus.req_valid[i] = 1'b0;
                if (!bus.req_valid[i]) begin
                    if ($urandom_range(0, 2) == 0)
                        set_req(i, rnd_opnd(), rnd_opnd(), 1'($urandom));
                end else if ($urandom_range(0, 19) == 0) begin
                    bus.req_valid[i] = 1'b0;
                end
            end
        end
        tick();
        bus.req_valid = '0;
        bus.res_ready = 1'b1;
        repeat (5) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
